axis_fifo: RTL and testbench
============================

# axis_fifo

Synchronous AXI-Stream FIFO that sits directly downstream of a stream master and absorbs its valid/ready traffic. It decouples the producer from a slower or stalling consumer, carries data plus an end-of-packet marker, and reports occupancy and complete-packet count for flow monitoring. First-word-fall-through: the head entry is presented on the master side as soon as it is stored.

## Interface
- DATA_WIDTH, 8, width of s_data / m_data
- DEPTH, 8, number of entries; power of two, minimum 2
- ADDR_WIDTH, $clog2(DEPTH), local, read/write address width

- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- s_data  in  DATA_WIDTH  write-side data
- s_last  in  1  write-side end-of-packet marker
- s_valid  in  1  write-side valid
- s_ready  out  1  write-side ready, registered
- m_data  out  DATA_WIDTH  head-of-FIFO data
- m_last  out  1  head-of-FIFO end-of-packet marker
- m_valid  out  1  head-of-FIFO valid, registered
- m_ready  in  1  read-side ready from consumer
- count  out  ADDR_WIDTH+1  entries currently stored, 0..DEPTH
- pkt_count  out  ADDR_WIDTH+1  stored entries with last=1

## Operation
- Write handshake: wr_en = s_valid & s_ready; stores {s_last, s_data} at wr_ptr, wr_ptr increments.
- Read handshake: rd_en = m_valid & m_ready; rd_ptr increments; m_data/m_last = mem[rd_ptr] combinationally.
- Pointers are ADDR_WIDTH+1 bits; low bits address memory, MSB distinguishes full from empty; natural wrap at 2*DEPTH.
- count_next = count + wr_en - rd_en; pkt_count_next = pkt_count + (wr_en & s_last) - (rd_en & m_last).
- s_ready registered: s_ready <= (count_next < DEPTH). m_valid registered: m_valid <= (count_next != 0).
- Full (count==DEPTH): s_ready=0, no write accepted even if a read occurs the same cycle; s_ready returns to 1 the cycle after the read.
- Empty (count==0): m_valid=0; m_data/m_last are don't-care; no read-through of a same-cycle write.
- Simultaneous write and read at 0<count<DEPTH: both complete, count unchanged, pkt_count adjusts per both last bits.
- s_valid must not depend on s_ready; m_valid never depends on m_ready; once m_valid=1 it and m_data stay stable until rd_en.
- Memory array is not reset; only pointers, counters and flags are.

## Timing
- Reset (reset_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, pkt_count=0, s_ready=0, m_valid=0; m_last/m_data don't-care.
- First rising edge after reset_n release: s_ready=1. No write can be accepted on that edge.
- Write-to-read latency: entry written on edge N appears with m_valid=1 after edge N (available for read on edge N+1).
- Throughput: one write and one read per cycle sustained while 0<count<DEPTH.
- Full-to-ready latency: read on edge N while full -> s_ready=1 after edge N.
- Reset mid-operation: all stored entries discarded immediately; outputs take reset values without waiting for clk.

## Test plan
- Reset release, DEPTH=8: s_ready=0, m_valid=0, count=0 during reset; s_ready=1 one edge after release, m_valid stays 0.
- Single beat: write 0x0A with s_last=1, m_ready=0 -> next cycle m_valid=1, m_data=0x0A, m_last=1, count=1, pkt_count=1; pulse m_ready -> count=0, m_valid=0.
- Fill: m_ready=0, write 0x01..0x08 -> count=8, s_ready=0; 9th s_valid beat 0x09 held, not stored; drain -> reads 0x01..0x08 in order, then 0x09 after s_ready returns.
- Full with simultaneous read/write: at count=8 assert m_ready and s_valid -> read completes, write blocked, count=7, s_ready=1 next cycle, then write accepted.
- Streaming with wrap: continuous s_valid/m_ready=1 for 40 beats of $urandom_range(0,15) with last every 4th beat -> output sequence identical, count never exceeds 1 after fill, pkt_count tracks stored lasts.
- Async reset mid-stream: assert reset_n=0 between edges at count=5 -> count, pkt_count, m_valid, s_ready go 0 immediately; post-reset reads return only newly written data.

Source files
------------

// File: rtl/axis_fifo.sv
// axis_fifo: first-word-fall-through AXI-Stream FIFO carrying data plus an
// end-of-packet marker, with occupancy and stored-packet monitoring outputs.
module axis_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_next;
  logic [ADDR_WIDTH:0] pkt_count_next;
  logic                wr_en;
  logic                rd_en;

  assign wr_en = s_valid & s_ready;
  assign rd_en = m_valid & m_ready;

  // Occupancy is the pointer distance; the extra MSB on each pointer makes
  // the full case (distance DEPTH) distinct from empty (distance 0).
  assign count = wr_ptr - rd_ptr;

  // Head entry is presented straight from the array (fall-through).
  assign {m_last, m_data} = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Next occupancy and next packet count from this cycle's handshakes.
  always_comb begin
    count_next     = count + {{ADDR_WIDTH{1'b0}}, wr_en}
                           - {{ADDR_WIDTH{1'b0}}, rd_en};
    pkt_count_next = pkt_count + {{ADDR_WIDTH{1'b0}}, wr_en & s_last}
                               - {{ADDR_WIDTH{1'b0}}, rd_en & m_last};
  end

  // Storage array, written on an accepted beat; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_last, s_data};
    end
  end

  // Pointers, packet count and registered handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      pkt_count <= pkt_count_next;
      s_ready   <= (count_next < FULL_LVL);
      m_valid   <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed self-checking bench for axis_fifo (DEPTH=8, 8-bit data).
module tb_axis_fifo;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic [AW:0]   pkt_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] stream_data [40];

  axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .count     (count),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;

    // Reset state and release
    tick();
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_count", count, 0);
    check("rst_pkt", pkt_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rel_s_ready", s_ready, 1);
    check("rel_m_valid", m_valid, 0);

    // Single beat
    s_valid = 1'b1; s_data = 8'h0A; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    check("one_m_valid", m_valid, 1);
    check("one_m_data", m_data, 32'h0A);
    check("one_m_last", m_last, 1);
    check("one_count", count, 1);
    check("one_pkt", pkt_count, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("one_rd_count", count, 0);
    check("one_rd_m_valid", m_valid, 0);
    check("one_rd_pkt", pkt_count, 0);

    // Fill 0x01..0x08, lasts on beats 4 and 8
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = DW'(i); s_last = (i == 4 || i == 8);
      tick();
    end
    s_data = 8'h09; s_last = 1'b0;
    check("full_count", count, 8);
    check("full_s_ready", s_ready, 0);
    check("full_pkt", pkt_count, 2);
    check("full_head", m_data, 32'h01);
    tick();
    check("held_count", count, 8);
    check("held_head", m_data, 32'h01);

    // Read while full with s_valid high: write blocked
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("fullrw_count", count, 7);
    check("fullrw_s_ready", s_ready, 1);
    check("fullrw_head", m_data, 32'h02);
    tick();
    s_valid = 1'b0;
    check("refill_count", count, 8);
    check("refill_s_ready", s_ready, 0);
    check("refill_pkt", pkt_count, 2);

    // Drain 0x02..0x09
    m_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      check("drain_valid", m_valid, 1);
      check("drain_data", m_data, 32'(i));
      check("drain_last", m_last, (i == 4 || i == 8) ? 32'd1 : 32'd0);
      tick();
    end
    m_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_m_valid", m_valid, 0);
    check("drain_pkt", pkt_count, 0);

    // Streaming with pointer wrap
    for (int i = 0; i < 40; i++) stream_data[i] = DW'($urandom_range(0, 15));
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1; s_data = stream_data[i]; s_last = (i % 4 == 3);
      tick();
      check("strm_valid", m_valid, 1);
      check("strm_data", m_data, 32'(stream_data[i]));
      check("strm_count", count, 1);
      check("strm_pkt", pkt_count, (i % 4 == 3) ? 32'd1 : 32'd0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    m_ready = 1'b0;
    check("strm_end_count", count, 0);
    check("strm_end_valid", m_valid, 0);

    // Asynchronous reset at count=5
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = DW'(8'h30 + i); s_last = (i == 1 || i == 3);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("pre_rst_count", count, 5);
    check("pre_rst_pkt", pkt_count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_pkt", pkt_count, 0);
    check("arst_m_valid", m_valid, 0);
    check("arst_s_ready", s_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("arst_rel_s_ready", s_ready, 1);
    check("arst_rel_m_valid", m_valid, 0);
    s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    check("post_data", m_data, 32'h55);
    check("post_count", count, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("post_rd_count", count, 0);
    check("post_rd_valid", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
